uart_rx_oversample: RTL and testbench

//  UART receiver that consumes the 16x baud_clock tick from the baud generator.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 39 +++
 rtl/uart_rx_oversample.sv | 125 ++++++++++++
 tb/tb_uart_rx_oversample.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and parity helper for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int TICKS_PER_BIT = 16;
  localparam int TICK_W        = $clog2(TICKS_PER_BIT);

  // Nonzero when the received parity bit disagrees with the data under the chosen sense.
  function automatic logic parity_error(input logic [7:0] data, input logic sample,
                                        input logic odd_n_even);
    return sample ^ (^data) ^ odd_n_even;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx synchroniser and per-bit decision
// UART_RX_MAJORITY_VOTE_EN: decision is the 2-of-3 vote of the last three tick samples.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic baud_clock,
  input  logic rx,
  output logic sample_o,
  output logic bit_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign sample_o = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Holds the samples from the two previous ticks; the current sample is the third voter.
  logic [1:0] vote_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        vote_q <= 2'b11;
    else if (baud_clock) vote_q <= {vote_q[0], sample_o};
  end

  assign bit_o = (vote_q[1] & vote_q[0]) | (vote_q[1] & sample_o) | (vote_q[0] & sample_o);
`else
  logic unused_baud_clock;
  assign unused_baud_clock = baud_clock;
  assign bit_o = sample_o;
`endif

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampling UART receiver with single-byte holding register
// UART_RX_MAJORITY_VOTE_EN: bit decisions move one tick later to use the 2-of-3 vote.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int MID_TICK    = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_LAT = 1;
`else
  localparam int VOTE_LAT = 0;
`endif
  localparam logic [TICK_W-1:0] DEC_TICK = TICK_W'(MID_TICK + VOTE_LAT);

  rx_state_t         state_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, last_bit;
  logic [7:0]        shift_q;
  logic              perr_q, prev_q;
  logic [7:0]        rx_data_q;
  logic              rx_ready_q, parity_err_q, framing_err_q, overflow_q;
  logic              sample, bit_v, dec;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_clock(baud_clock),
    .rx        (rx),
    .sample_o  (sample),
    .bit_o     (bit_v)
  );

  assign tick_d   = tick_q + TICK_W'(1);
  assign last_bit = bit8 ? 3'd7 : 3'd6;
  assign dec      = (tick_q == DEC_TICK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      perr_q        <= 1'b0;
      prev_q        <= 1'b1;
      rx_data_q     <= '0;
      rx_ready_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (read_rx_byte) begin
        rx_ready_q    <= 1'b0;
        parity_err_q  <= 1'b0;
        framing_err_q <= 1'b0;
        overflow_q    <= 1'b0;
      end
      if (baud_clock) begin
        prev_q <= sample;
        tick_q <= tick_d;
        unique case (state_q)
          IDLE: if (prev_q && !sample) begin
            state_q <= START;
            tick_q  <= '0;
          end
          START: if (dec) begin
            if (!bit_v) begin
              state_q <= DATA;
              bit_q   <= '0;
              shift_q <= '0;
              perr_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
          DATA: if (dec) begin
            shift_q[bit_q] <= bit_v;
            if (bit_q >= last_bit) begin
              bit_q   <= '0;
              state_q <= parity_en ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
          PARITY: if (dec) begin
            perr_q  <= parity_error(shift_q, bit_v, odd_n_even);
            state_q <= STOP;
          end
          STOP: if (dec) begin
            // A completing byte outranks a same-cycle read: the new byte stays pending.
            rx_data_q     <= shift_q;
            parity_err_q  <= perr_q;
            framing_err_q <= ~bit_v;
            rx_ready_q    <= 1'b1;
            if (rx_ready_q && !read_rx_byte) overflow_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_ready    = rx_ready_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - scoreboard bench for uart_rx_oversample
module tb_uart_rx_oversample;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE = 1;
`else
  localparam int VOTE = 0;
`endif
  localparam int MID = 7;

  logic       clk = 1'b0;
  logic       reset_n, baud_clock, rx, bit8, parity_en, odd_n_even, read_rx_byte;
  logic [7:0] rx_data;
  logic       rx_ready, parity_err, framing_err, overflow;

  uart_rx_oversample #(.MID_TICK(MID), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_clock  (baud_clock),
    .rx          (rx),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .read_rx_byte(read_rx_byte),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  logic [1:0]  div = 2'd0;
  int unsigned tick_num = 0;
  initial baud_clock = 1'b0;
  always @(posedge clk) begin
    div        <= div + 2'd1;
    baud_clock <= (div == 2'd3);
    if (baud_clock) tick_num <= tick_num + 1;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passes++;
  endtask

  // Monitor: a byte is presented when rx_ready rises, the held data changes, or overflow rises.
  logic       prev_ready = 1'b0, prev_ovf = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic on_byte();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_byte: got data=%h with no byte expected", rx_data);
    end else begin
      e = exp_q.pop_front();
      check("rx_data", int'(rx_data), int'(e.data));
      check("parity_err", int'(parity_err), int'(e.perr));
      check("framing_err", int'(framing_err), int'(e.ferr));
      check("overflow", int'(overflow), int'(e.ovf));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rx_ready &&
        (!prev_ready || rx_data != prev_data || (overflow && !prev_ovf)))
      on_byte();
    prev_ready <= rx_ready;
    prev_data  <= rx_data;
    prev_ovf   <= overflow;
  end

  task automatic wait_tick(input int unsigned target);
    int n = 0;
    while (tick_num < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (tick_num < target) begin
      checks++;
      $display("FAIL wait_tick_timeout: tick=%0d target=%0d", tick_num, target);
    end
  endtask

  task automatic pulse_read();
    read_rx_byte = 1'b1;
    @(negedge clk);
    read_rx_byte = 1'b0;
  endtask

  // Read pulse aligned to the clock edge that consumes tick number c.
  task automatic read_at_tick(input int unsigned c);
    int n = 0;
    wait_tick(c - 1);
    while (!baud_clock && n < 8) begin
      @(negedge clk);
      n++;
    end
    pulse_read();
  endtask

  // Frame is driven from just after a tick so detection lands on tick t0+1.
  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input logic par_bit, input logic stop_bit, input int spike_bit,
                            input int nsend);
    logic [11:0] bits;
    int          n;
    int unsigned t0;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[1+i] = data[i];
    n = 1 + nbits;
    if (par_en) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    if (nsend > 0) n = nsend;
    t0 = tick_num + 1;
    for (int i = 0; i < n; i++) begin
      wait_tick(t0 + 16 * i);
      rx = bits[i];
      if (i == spike_bit) begin
        wait_tick(t0 + 16 * i + MID);
        rx = 1'b1;
        wait_tick(t0 + 16 * i + MID + 1);
        rx = bits[i];
      end
    end
    if (nsend > 0) wait_tick(t0 + 16 * (n - 1) + 8);
    else           wait_tick(t0 + 16 * n);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    e.ovf  = ov;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_rx_data"}, int'(rx_data), 0);
    check({nm, "_rx_ready"}, int'(rx_ready), 0);
    check({nm, "_parity_err"}, int'(parity_err), 0);
    check({nm, "_framing_err"}, int'(framing_err), 0);
    check({nm, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int unsigned tn;
    reset_n = 1'b0; rx = 1'b1; read_rx_byte = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    wait_tick(tick_num + 20);

    // 8N1 0xA5
    expect_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    pulse_read();
    @(negedge clk);
    check("read_clears_ready", int'(rx_ready), 0);

    // 7E1 0x35 (four ones: even parity bit 0), then parity bit flipped
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    expect_byte(8'h35, 1'b0, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, -1, 0);
    pulse_read();
    expect_byte(8'h35, 1'b1, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, -1, 0);
    pulse_read();
    @(negedge clk);
    check("read_clears_parity_err", int'(parity_err), 0);
    bit8 = 1'b1; parity_en = 1'b0;

    // Framing error, then line held low for three bit times
    expect_byte(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, -1, 0);
    wait_tick(tick_num + 48);
    rx = 1'b1;
    wait_tick(tick_num + 16);
    pulse_read();

    // Start glitch of 4 ticks
    tn = tick_num + 1;
    wait_tick(tn);
    rx = 1'b0;
    wait_tick(tn + 4);
    rx = 1'b1;
    wait_tick(tn + 40);
    check("glitch_no_ready", int'(rx_ready), 0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    expect_byte(8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 4, 0);
    pulse_read();
`endif

    // Overflow: 0x11, 0x22 unread, then 0x33 completing on the same edge as a read
    expect_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    expect_byte(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    expect_byte(8'h33, 1'b0, 1'b0, 1'b0);
    tn = tick_num + 1;
    fork
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, -1, 0);
      read_at_tick(tn + 152 + VOTE);
    join
    check("overflow_read_ready", int'(rx_ready), 1);

    // Reset in the middle of data bit 4
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, -1, 6);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    check_outputs_zero("midframe_reset");
    reset_n = 1'b1;
    wait_tick(tick_num + 32);
    expect_byte(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    pulse_read();

    wait_tick(tick_num + 20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
